// File: rtl/command_decoder.sv
`default_nettype none
// ============================================================================
// Module      : command_decoder
// Description : Host byte-stream decoder sitting in front of the cursor block.
//               Decodes printable characters, C0 controls (CR, BS, TAB, LF)
//               and VT52 escape sequences. It emits character-buffer writes,
//               new cursor positions and scroll requests. The current cursor
//               position is fed back from the cursor block.
//               Build option: define CMD_DIRECT_ADDR_EN to support direct
//               cursor addressing (ESC Y row col). When it is not defined,
//               ESC Y is treated as an unknown escape.
// Revision    : 1.0 - initial release
// ============================================================================
module command_decoder #(
  parameter int ROW_BITS = 5,
  parameter int COL_BITS = 7,
  parameter int ROWS     = 24,
  parameter int COLS     = 80
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          data,
  input  logic                valid,
  output logic                ready,
  input  logic [COL_BITS-1:0] cursor_x,
  input  logic [ROW_BITS-1:0] cursor_y,
  output logic [COL_BITS-1:0] new_cursor_x,
  output logic [ROW_BITS-1:0] new_cursor_y,
  output logic                new_cursor_wen,
  output logic [7:0]          buf_char,
  output logic [COL_BITS-1:0] buf_x,
  output logic [ROW_BITS-1:0] buf_y,
  output logic                buf_wen,
  output logic                scroll_req
);

  // Coordinate limits, held one bit wider than the coordinates so that
  // increments can be compared before they are clamped.
  localparam logic [COL_BITS:0] c_col_max = (COL_BITS+1)'(COLS-1);
  localparam logic [ROW_BITS:0] c_row_max = (ROW_BITS+1)'(ROWS-1);
  localparam logic [COL_BITS:0] c_x_one   = (COL_BITS+1)'(1);
  localparam logic [ROW_BITS:0] c_y_one   = (ROW_BITS+1)'(1);
  localparam logic [COL_BITS:0] c_tab_low = (COL_BITS+1)'(7);
  localparam logic [COL_BITS:0] c_x_zero  = '0;
  localparam logic [ROW_BITS:0] c_y_zero  = '0;

  // Byte codes
  localparam logic [7:0] c_sp   = 8'h20;
  localparam logic [7:0] c_tilde = 8'h7E;
  localparam logic [7:0] c_bs   = 8'h08;
  localparam logic [7:0] c_tab  = 8'h09;
  localparam logic [7:0] c_lf   = 8'h0A;
  localparam logic [7:0] c_cr   = 8'h0D;
  localparam logic [7:0] c_esc  = 8'h1B;
  localparam logic [7:0] c_up   = 8'h41;  // 'A'
  localparam logic [7:0] c_down = 8'h42;  // 'B'
  localparam logic [7:0] c_rght = 8'h43;  // 'C'
  localparam logic [7:0] c_left = 8'h44;  // 'D'
  localparam logic [7:0] c_home = 8'h48;  // 'H'

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ESC   = 2'd1
`ifdef CMD_DIRECT_ADDR_EN
    ,
    ST_Y_ROW = 2'd2,
    ST_Y_COL = 2'd3
`endif
  } state_t;

  // Saturate a widened column value to the last visible column.
  function automatic logic [COL_BITS-1:0] clamp_x(input logic [COL_BITS:0] v);
    clamp_x = (v > c_col_max) ? c_col_max[COL_BITS-1:0] : v[COL_BITS-1:0];
  endfunction

  // Saturate a widened row value to the last visible row.
  function automatic logic [ROW_BITS-1:0] clamp_y(input logic [ROW_BITS:0] v);
    clamp_y = (v > c_row_max) ? c_row_max[ROW_BITS-1:0] : v[ROW_BITS-1:0];
  endfunction

  // Registered state and outputs
  state_t              r_state;
  logic                r_ready;
  logic [COL_BITS-1:0] r_new_x;
  logic [ROW_BITS-1:0] r_new_y;
  logic                r_new_wen;
  logic [7:0]          r_buf_char;
  logic [COL_BITS-1:0] r_buf_x;
  logic [ROW_BITS-1:0] r_buf_y;
  logic                r_buf_wen;
  logic                r_scroll;

  // Next-state values
  state_t              w_state_nxt;
  logic                w_ready_nxt;
  logic [COL_BITS-1:0] w_new_x_nxt;
  logic [ROW_BITS-1:0] w_new_y_nxt;
  logic                w_new_wen_nxt;
  logic [7:0]          w_buf_char_nxt;
  logic [COL_BITS-1:0] w_buf_x_nxt;
  logic [ROW_BITS-1:0] w_buf_y_nxt;
  logic                w_buf_wen_nxt;
  logic                w_scroll_nxt;

  // Widened cursor arithmetic
  logic                w_accept;
  logic [COL_BITS:0]   w_x_w;
  logic [ROW_BITS:0]   w_y_w;
  logic [COL_BITS:0]   w_x_inc;
  logic [COL_BITS:0]   w_x_dec;
  logic [COL_BITS:0]   w_x_tab;
  logic [ROW_BITS:0]   w_y_inc;
  logic [ROW_BITS:0]   w_y_dec;
  logic [COL_BITS-1:0] w_x_cur;
  logic [ROW_BITS-1:0] w_y_cur;

  assign w_accept = valid & r_ready;
  assign w_x_w    = {1'b0, cursor_x};
  assign w_y_w    = {1'b0, cursor_y};
  assign w_x_inc  = w_x_w + c_x_one;
  assign w_y_inc  = w_y_w + c_y_one;
  assign w_x_dec  = (w_x_w == c_x_zero) ? c_x_zero : (w_x_w - c_x_one);
  assign w_y_dec  = (w_y_w == c_y_zero) ? c_y_zero : (w_y_w - c_y_one);
  assign w_x_tab  = (w_x_w | c_tab_low) + c_x_one;
  // The unchanged coordinate of a move is still clamped so that an
  // out-of-range feedback value can never leak onto the outputs.
  assign w_x_cur  = clamp_x(w_x_w);
  assign w_y_cur  = clamp_y(w_y_w);

`ifdef CMD_DIRECT_ADDR_EN
  // Row byte of an ESC Y sequence, held until the column byte arrives.
  logic [7:0] r_row_byte;
  logic [7:0] w_row_byte_nxt;
  logic [7:0] w_row_off;
  logic [7:0] w_col_off;
  logic       w_row_ok;
  logic       w_col_ok;

  assign w_row_off = r_row_byte - c_sp;
  assign w_col_off = data - c_sp;
  assign w_row_ok  = (r_row_byte >= c_sp) && (w_row_off < 8'(ROWS));
  assign w_col_ok  = (data >= c_sp) && (w_col_off < 8'(COLS));

  // Row byte latch, cleared by reset so a partial sequence is discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row_byte <= '0;
    end else begin
      r_row_byte <= w_row_byte_nxt;
    end
  end
`endif

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b1;
      r_new_x    <= '0;
      r_new_y    <= '0;
      r_new_wen  <= 1'b0;
      r_buf_char <= '0;
      r_buf_x    <= '0;
      r_buf_y    <= '0;
      r_buf_wen  <= 1'b0;
      r_scroll   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ready    <= w_ready_nxt;
      r_new_x    <= w_new_x_nxt;
      r_new_y    <= w_new_y_nxt;
      r_new_wen  <= w_new_wen_nxt;
      r_buf_char <= w_buf_char_nxt;
      r_buf_x    <= w_buf_x_nxt;
      r_buf_y    <= w_buf_y_nxt;
      r_buf_wen  <= w_buf_wen_nxt;
      r_scroll   <= w_scroll_nxt;
    end
  end

  // Decode of the accepted byte: next state and next output values
  always_comb begin
    w_state_nxt    = r_state;
    // A byte taken this cycle blocks the next one for a cycle so the
    // cursor block can reflect the update before the next decode.
    w_ready_nxt    = ~w_accept;
    w_new_x_nxt    = r_new_x;
    w_new_y_nxt    = r_new_y;
    w_new_wen_nxt  = 1'b0;
    w_buf_char_nxt = r_buf_char;
    w_buf_x_nxt    = r_buf_x;
    w_buf_y_nxt    = r_buf_y;
    w_buf_wen_nxt  = 1'b0;
    w_scroll_nxt   = 1'b0;
`ifdef CMD_DIRECT_ADDR_EN
    w_row_byte_nxt = r_row_byte;
`endif

    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if ((data >= c_sp) && (data <= c_tilde)) begin
            // Printable: write at the cursor, then advance without wrap
            w_buf_wen_nxt  = 1'b1;
            w_buf_char_nxt = data;
            w_buf_x_nxt    = w_x_cur;
            w_buf_y_nxt    = w_y_cur;
            w_new_wen_nxt  = 1'b1;
            w_new_x_nxt    = clamp_x(w_x_inc);
            w_new_y_nxt    = w_y_cur;
          end else begin
            case (data)
              c_cr: begin
                w_new_wen_nxt = 1'b1;
                w_new_x_nxt   = '0;
                w_new_y_nxt   = w_y_cur;
              end
              c_bs: begin
                w_new_wen_nxt = 1'b1;
                w_new_x_nxt   = clamp_x(w_x_dec);
                w_new_y_nxt   = w_y_cur;
              end
              c_tab: begin
                w_new_wen_nxt = 1'b1;
                w_new_x_nxt   = clamp_x(w_x_tab);
                w_new_y_nxt   = w_y_cur;
              end
              c_lf: begin
                // On the bottom row the screen scrolls instead of the cursor
                w_new_wen_nxt = 1'b1;
                w_new_x_nxt   = w_x_cur;
                if (w_y_w < c_row_max) begin
                  w_new_y_nxt = clamp_y(w_y_inc);
                end else begin
                  w_new_y_nxt  = w_y_cur;
                  w_scroll_nxt = 1'b1;
                end
              end
              c_esc: begin
                w_state_nxt = ST_ESC;
              end
              default: begin
              end
            endcase
          end
        end

        ST_ESC: begin
          w_state_nxt = ST_IDLE;
          case (data)
            c_up: begin
              w_new_wen_nxt = 1'b1;
              w_new_x_nxt   = w_x_cur;
              w_new_y_nxt   = clamp_y(w_y_dec);
            end
            c_down: begin
              w_new_wen_nxt = 1'b1;
              w_new_x_nxt   = w_x_cur;
              w_new_y_nxt   = clamp_y(w_y_inc);
            end
            c_rght: begin
              w_new_wen_nxt = 1'b1;
              w_new_x_nxt   = clamp_x(w_x_inc);
              w_new_y_nxt   = w_y_cur;
            end
            c_left: begin
              w_new_wen_nxt = 1'b1;
              w_new_x_nxt   = clamp_x(w_x_dec);
              w_new_y_nxt   = w_y_cur;
            end
            c_home: begin
              w_new_wen_nxt = 1'b1;
              w_new_x_nxt   = '0;
              w_new_y_nxt   = '0;
            end
`ifdef CMD_DIRECT_ADDR_EN
            8'h59: begin  // 'Y'
              w_state_nxt = ST_Y_ROW;
            end
`endif
            default: begin
            end
          endcase
        end

`ifdef CMD_DIRECT_ADDR_EN
        ST_Y_ROW: begin
          w_row_byte_nxt = data;
          w_state_nxt    = ST_Y_COL;
        end

        ST_Y_COL: begin
          // Out-of-range row keeps the row; out-of-range column pins right
          w_state_nxt   = ST_IDLE;
          w_new_wen_nxt = 1'b1;
          w_new_y_nxt   = w_row_ok ? w_row_off[ROW_BITS-1:0] : w_y_cur;
          w_new_x_nxt   = w_col_ok ? w_col_off[COL_BITS-1:0] : c_col_max[COL_BITS-1:0];
        end
`endif

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign ready          = r_ready;
  assign new_cursor_x   = r_new_x;
  assign new_cursor_y   = r_new_y;
  assign new_cursor_wen = r_new_wen;
  assign buf_char       = r_buf_char;
  assign buf_x          = r_buf_x;
  assign buf_y          = r_buf_y;
  assign buf_wen        = r_buf_wen;
  assign scroll_req     = r_scroll;

endmodule
`default_nettype wire

// File: tb/tb_command_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_command_decoder
// Description : Self-checking bench for command_decoder. A behavioural model
//               of the decoder is compared against every output on every
//               cycle; directed vectors add literal expectations. The bench
//               plays the cursor block by loading the new cursor position.
//               Honours CMD_DIRECT_ADDR_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_command_decoder;

  localparam int ROWS = 24;
  localparam int COLS = 80;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       valid = 1'b0;
  logic [6:0] cx    = 7'd0;
  logic [4:0] cy    = 5'd0;
  logic       ready;
  logic [6:0] new_cursor_x;
  logic [4:0] new_cursor_y;
  logic       new_cursor_wen;
  logic [7:0] buf_char;
  logic [6:0] buf_x;
  logic [4:0] buf_y;
  logic       buf_wen;
  logic       scroll_req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  command_decoder #(
    .ROW_BITS(5), .COL_BITS(7), .ROWS(ROWS), .COLS(COLS)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .valid(valid), .ready(ready),
    .cursor_x(cx), .cursor_y(cy),
    .new_cursor_x(new_cursor_x), .new_cursor_y(new_cursor_y),
    .new_cursor_wen(new_cursor_wen),
    .buf_char(buf_char), .buf_x(buf_x), .buf_y(buf_y), .buf_wen(buf_wen),
    .scroll_req(scroll_req)
  );

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 after ESC, 2 waiting row byte, 3 waiting column byte
  typedef struct packed {
    int mode; int row; int ch; int bx; int by; int nx; int ny;
    logic bw; logic cw; logic sc;
  } step_t;

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  function automatic step_t step(int mode, int row, int b, int x, int y);
    step_t s;
    s = '0;
    s.row = row;
    s.nx = x;
    s.ny = y;
    case (mode)
      0: begin
        if (b >= 32 && b <= 126) begin
          s.bw = 1'b1; s.ch = b; s.bx = x; s.by = y;
          s.cw = 1'b1; s.nx = imin(x + 1, COLS - 1);
        end else if (b == 13) begin
          s.cw = 1'b1; s.nx = 0;
        end else if (b == 8) begin
          s.cw = 1'b1; s.nx = imax(x - 1, 0);
        end else if (b == 9) begin
          s.cw = 1'b1; s.nx = imin((x | 7) + 1, COLS - 1);
        end else if (b == 10) begin
          s.cw = 1'b1;
          if (y < ROWS - 1) s.ny = y + 1;
          else s.sc = 1'b1;
        end else if (b == 27) begin
          s.mode = 1;
        end
      end
      1: begin
        s.cw = 1'b1;
        if (b == 'h41) s.ny = imax(y - 1, 0);
        else if (b == 'h42) s.ny = imin(y + 1, ROWS - 1);
        else if (b == 'h43) s.nx = imin(x + 1, COLS - 1);
        else if (b == 'h44) s.nx = imax(x - 1, 0);
        else if (b == 'h48) begin s.nx = 0; s.ny = 0; end
`ifdef CMD_DIRECT_ADDR_EN
        else if (b == 'h59) begin s.cw = 1'b0; s.mode = 2; end
`endif
        else s.cw = 1'b0;
      end
      2: begin
        s.row = b; s.mode = 3;
      end
      default: begin
        s.cw = 1'b1;
        s.ny = (row >= 32 && row - 32 < ROWS) ? row - 32 : y;
        s.nx = (b >= 32 && b - 32 < COLS) ? b - 32 : COLS - 1;
      end
    endcase
    return s;
  endfunction

  step_t m_s;
  int    m_mode, m_row, m_bc, m_bx, m_by, m_nx, m_ny;
  logic  m_ready, m_bw, m_cw, m_sc;

  always_comb m_s = step(m_mode, m_row, int'(data), int'(cx), int'(cy));

  // Model registers: one byte per handshake, pulses last one cycle
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode <= 0; m_row <= 0; m_ready <= 1'b1;
      m_bw <= 1'b0; m_cw <= 1'b0; m_sc <= 1'b0;
      m_bc <= 0; m_bx <= 0; m_by <= 0; m_nx <= 0; m_ny <= 0;
    end else begin
      m_bw <= 1'b0; m_cw <= 1'b0; m_sc <= 1'b0;
      m_ready <= !(valid && m_ready);
      if (valid && m_ready) begin
        m_mode <= m_s.mode; m_row <= m_s.row;
        m_bw <= m_s.bw; m_cw <= m_s.cw; m_sc <= m_s.sc;
        if (m_s.bw) begin m_bc <= m_s.ch; m_bx <= m_s.bx; m_by <= m_s.by; end
        if (m_s.cw) begin m_nx <= m_s.nx; m_ny <= m_s.ny; end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: wait for the falling edge and compare every output
  task automatic tick();
    @(negedge clk);
    chk("ready",    int'(ready),          int'(m_ready));
    chk("buf_wen",  int'(buf_wen),        int'(m_bw));
    chk("cur_wen",  int'(new_cursor_wen), int'(m_cw));
    chk("scroll",   int'(scroll_req),     int'(m_sc));
    chk("buf_char", int'(buf_char),       m_bc);
    chk("buf_x",    int'(buf_x),          m_bx);
    chk("buf_y",    int'(buf_y),          m_by);
    chk("new_x",    int'(new_cursor_x),   m_nx);
    chk("new_y",    int'(new_cursor_y),   m_ny);
  endtask

  // Pulses seen during the cycle after the last accepted byte
  logic p_bw, p_cw, p_sc, p_rdy;

  // Send one byte, then act as the cursor block and load the new position
  task automatic send(input logic [7:0] b);
    data  = b;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    p_bw = buf_wen; p_cw = new_cursor_wen; p_sc = scroll_req; p_rdy = ready;
    if (m_cw) begin cx = 7'(m_nx); cy = 5'(m_ny); end
    tick();
  endtask

  task automatic setc(input int x, input int y);
    cx = 7'(x);
    cy = 5'(y);
  endtask

  initial begin
    int x0, y0;
    // Reset state
    tick();
    tick();
    chk("rst_ready", int'(ready), 1);
    chk("rst_newx", int'(new_cursor_x), 0);
    reset = 1'b1;
    tick();

    // 1: 'A' at (0,0)
    setc(0, 0);
    send(8'h41);
    chk("t1_bw", int'(p_bw), 1);
    chk("t1_rdy_low", int'(p_rdy), 0);
    chk("t1_char", int'(buf_char), 'h41);
    chk("t1_bxy", int'({buf_x, buf_y}), 0);
    chk("t1_cw", int'(p_cw), 1);
    chk("t1_nx", int'(new_cursor_x), 1);
    chk("t1_ny", int'(new_cursor_y), 0);

    // 2: 'Z' at the right margin
    setc(79, 5);
    send(8'h5A);
    chk("t2_bx", int'(buf_x), 79);
    chk("t2_by", int'(buf_y), 5);
    chk("t2_nx", int'(new_cursor_x), 79);
    chk("t2_ny", int'(new_cursor_y), 5);

    // 3: LF on bottom row scrolls; ESC B there does not
    setc(10, 23);
    send(8'h0A);
    chk("t3_sc", int'(p_sc), 1);
    chk("t3_ny", int'(new_cursor_y), 23);
    send(8'h1B);
    chk("t3_esc_cw", int'(p_cw), 0);
    send(8'h42);
    chk("t3_b_sc", int'(p_sc), 0);
    chk("t3_b_cw", int'(p_cw), 1);
    chk("t3_b_xy", int'(new_cursor_x) * 100 + int'(new_cursor_y), 1023);

    // 4: direct addressing
    send(8'h1B); send(8'h59); send(8'h25);
`ifdef CMD_DIRECT_ADDR_EN
    chk("t4_row_nop", int'(p_cw | p_bw), 0);
    send(8'h2A);
    chk("t4_x", int'(new_cursor_x), 10);
    chk("t4_y", int'(new_cursor_y), 5);
    send(8'h1B); send(8'h59); send(8'h40); send(8'h7F);
    chk("t4_x2", int'(new_cursor_x), 79);
    chk("t4_y2", int'(new_cursor_y), 5);
`else
    chk("t4_pct_bw", int'(p_bw), 1);
    chk("t4_pct", int'(buf_char), 'h25);
    chk("t4_pct_x", int'(buf_x), 10);
`endif

    // 5: backspace saturation and tab clamp
    setc(3, 2);
    send(8'h08); chk("t5_bs1", int'(new_cursor_x), 2);
    send(8'h08); chk("t5_bs2", int'(new_cursor_x), 1);
    send(8'h08); chk("t5_bs3", int'(new_cursor_x), 0);
    send(8'h08); chk("t5_bs4", int'(new_cursor_x), 0);
    chk("t5_bs4_cw", int'(p_cw), 1);
    send(8'h09); chk("t5_tab0", int'(new_cursor_x), 8);
    setc(77, 2);
    send(8'h09); chk("t5_tab77", int'(new_cursor_x), 79);

    // Misc: ignored bytes, ESC ESC, CR, cursor keys, home
    setc(40, 0);
    send(8'h00); chk("ig_nul", int'(p_cw | p_bw), 0);
    send(8'h7F); chk("ig_del", int'(p_cw | p_bw), 0);
    send(8'h1B); send(8'h1B); send(8'h43);
    chk("escesc_print", int'(buf_char), 'h43);
    chk("escesc_bw", int'(p_bw), 1);
    send(8'h1B); send(8'h41); chk("esc_a_top", int'(new_cursor_y), 0);
    send(8'h1B); send(8'h44); chk("esc_d", int'(new_cursor_x), 40);
    send(8'h1B); send(8'h43); chk("esc_c", int'(new_cursor_x), 41);
    send(8'h0A); send(8'h0A); chk("lf2", int'(new_cursor_y), 2);
    send(8'h0D); chk("cr", int'(new_cursor_x), 0);
    send(8'h1B); send(8'h51); chk("esc_q", int'(p_cw), 0);
    send(8'h1B); send(8'h48);
    chk("home", int'(new_cursor_x) + int'(new_cursor_y), 0);

    // Valid held high: one byte every two cycles
    setc(20, 3);
    valid = 1'b1;
    data  = 8'h61;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (m_cw) begin cx = 7'(m_nx); cy = 5'(m_ny); end
    end
    valid = 1'b0;
    tick();
    chk("burst_x", int'(new_cursor_x), 23);

    // 6: reset in the middle of an escape sequence
    setc(4, 7);
    send(8'h1B); send(8'h59); send(8'h25);
    reset = 1'b0;
    tick();
    chk("t6_rst_x", int'(new_cursor_x), 0);
    chk("t6_rst_ch", int'(buf_char), 0);
    tick();
    reset = 1'b1;
    tick();
    x0 = int'(cx);
    y0 = int'(cy);
    send(8'h2A);
    chk("t6_bw", int'(p_bw), 1);
    chk("t6_char", int'(buf_char), 'h2A);
    chk("t6_bx", int'(buf_x), x0);
    chk("t6_by", int'(buf_y), y0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
